hm2_gpio_infilter: RTL and testbench
====================================

# hm2_gpio_infilter

Input-conditioning stage on the DE0-Nano-SoC GPIO header path. It samples the pin levels read back from the shared GPIO/hm2_iobits net and synchronizes each bit into the hostmot2 clock domain. Each bit then passes through a per-bit programmable glitch filter. The block produces clean levels, single-cycle edge strobes, and two pulse-stretched activity indicators (one per DB25 connector half) for hostmot2 input and the board LEDs.

## Interface

Parameters:
- IOWidth, 34, number of hostmot2 I/O bits conditioned.
- FilterBits, 4, width of `filter_len` and of each per-bit stability counter.
- LedStretch, 22, width of each activity-LED stretch counter.

Ports:
- clk  in  1  hostmot2 clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- gpio_in  in  IOWidth  raw pin levels, asynchronous to clk.
- filter_en  in  IOWidth  per-bit filter enable; 0 = bypass (sync only).
- filter_len  in  FilterBits  stability requirement N, shared by all enabled bits.
- io_filtered  out  IOWidth  conditioned level.
- edge_rise  out  IOWidth  one-cycle strobe on io_filtered 0->1.
- edge_fall  out  IOWidth  one-cycle strobe on io_filtered 1->0.
- act_led  out  2  stretched activity; [0] covers bits [IOWidth/2-1:0], [1] covers the remainder.

## Operation

- **Synchronizer.** Per bit, a 2-FF chain s1 <= gpio_in, s2 <= s1. No logic between the two flops.
- **Filter, enabled bit** (per-bit counter cnt, FilterBits wide):
  - s2 == io_filtered: cnt <= 0.
  - s2 != io_filtered and cnt >= filter_len: io_filtered <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
  - Result: a new level must be present on s2 for N+1 consecutive cycles. A shorter run is discarded and cnt is cleared.
  - The `>=` compare covers `filter_len` being lowered mid-count: the update fires on the next differing cycle.
  - cnt never exceeds 2^FilterBits-1, so there is no wrap-around.
- **Filter, bypassed bit** (`filter_en`=0): io_filtered <= s2 and cnt <= 0 every cycle. Toggling `filter_en` takes effect on the next edge and needs no flush.
- **Edges.** edge_rise/edge_fall are registered alongside io_filtered. They are high exactly in the cycle io_filtered first shows its new value. At most one of the two is set per bit per cycle.
- **Activity LEDs.**
  - Per group g, counter led_cnt[g] is LedStretch wide.
  - Any edge_rise or edge_fall in group g loads all-ones; otherwise the counter decrements when nonzero.
  - act_led[g] = (led_cnt[g] != 0), driven from the registered counter.
  - A new edge while counting reloads the counter; there is no extension beyond all-ones.
- **Reset.** Asynchronous; clears s1, s2, cnt, io_filtered, edge_rise, edge_fall, led_cnt.
  - Reset asserted mid-filter discards the pending count.
  - After release, a pin held high is treated as a 0->1 transition: edge_rise fires after the normal latency.

## Timing

- **Reference point.** The pin is stable before rising edge E0, so s1 updates at E0 and s2 at E1.
- **Bypass.** io_filtered and the edge strobe update at E2 (2-cycle latency); the strobe clears at E3.
- **Filter N.** io_filtered and the strobe update at E2+N, given s2 stays stable from E1 through E1+N.
- **LED.** act_led[g] rises at the edge after the strobe and stays high exactly 2^LedStretch-1 cycles after the last reload.
- **Reset values.** Every output is 0 during reset and until the first post-release update.
- **Simultaneous events.** Edges on several bits in one cycle are independent. For the LEDs they count as one reload.
- **Outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset:** hold gpio_in=all-ones during reset, release. Require all outputs 0 during reset; io_filtered=all-ones and edge_rise=all-ones for one cycle at E2; act_led=2'b11 from the next cycle.
- **Bypass latency:** FilterBits=4, filter_en=0; raise gpio_in[5] before E0. Require io_filtered[5]=1 at E2, edge_rise[5] high for one cycle only, all other bits quiet.
- **Glitch reject:** filter_en[0]=1, filter_len=3. A 3-cycle high pulse on bit 0 leaves io_filtered[0]=0 with no strobe. A 4-cycle-stable high updates at E5 with edge_rise[0].
- **Filter length change:** filter_len=10; bit 3 differs for 6 cycles, then filter_len=2. Require io_filtered[3] to update on the next cycle; cnt returns to 0.
- **LED stretch:** LedStretch=4; single edge on bit 20. Require act_led=2'b10 for exactly 15 cycles. A second edge 10 cycles after the first keeps it high 15 cycles past the second strobe (25 total).
- **Reset mid-operation:** filter_len=5; bit 7 differing for 4 cycles, then reset pulse, pin kept high. Require the count restarts from 0 and the update arrives at E2+5 relative to release.

Source files
------------

// File: rtl/hm2_gpio_infilter.sv
// Input conditioning for the hostmot2 GPIO header: 2-FF synchronizer, per-bit
// programmable glitch filter, edge strobes and per-half activity LED stretchers.
module hm2_gpio_infilter #(
  parameter int IOWidth    = 34,
  parameter int FilterBits = 4,
  parameter int LedStretch = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IOWidth-1:0]    gpio_in,
  input  logic [IOWidth-1:0]    filter_en,
  input  logic [FilterBits-1:0] filter_len,
  output logic [IOWidth-1:0]    io_filtered,
  output logic [IOWidth-1:0]    edge_rise,
  output logic [IOWidth-1:0]    edge_fall,
  output logic [1:0]            act_led
);

  localparam int HalfWidth = IOWidth / 2;

  logic [IOWidth-1:0]    s1;
  logic [IOWidth-1:0]    s2;
  logic [FilterBits-1:0] cnt      [IOWidth];
  logic [FilterBits-1:0] cnt_next [IOWidth];
  logic [IOWidth-1:0]    filt_next;
  logic [IOWidth-1:0]    any_edge;
  logic [1:0]            grp_edge;
  logic [LedStretch-1:0] led_cnt  [2];

  // A new level is accepted once cnt has reached filter_len on a differing
  // cycle; the >= keeps a mid-count lowering of filter_len from stalling.
  always_comb begin
    filt_next = io_filtered;
    for (int i = 0; i < IOWidth; i++) begin
      cnt_next[i] = '0;
      if (!filter_en[i]) begin
        filt_next[i] = s2[i];
      end else if (s2[i] != io_filtered[i]) begin
        if (cnt[i] >= filter_len) begin
          filt_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      io_filtered <= '0;
      edge_rise   <= '0;
      edge_fall   <= '0;
      for (int i = 0; i < IOWidth; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= gpio_in;
      s2          <= s1;
      io_filtered <= filt_next;
      edge_rise   <= filt_next & ~io_filtered;
      edge_fall   <= ~filt_next & io_filtered;
      for (int i = 0; i < IOWidth; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Several simultaneous edges in one half collapse into a single reload.
  always_comb begin
    any_edge    = edge_rise | edge_fall;
    grp_edge[0] = |any_edge[HalfWidth-1:0];
    grp_edge[1] = |any_edge[IOWidth-1:HalfWidth];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_cnt[0] <= '0;
      led_cnt[1] <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (grp_edge[g]) begin
          led_cnt[g] <= '1;
        end else if (led_cnt[g] != '0) begin
          led_cnt[g] <= led_cnt[g] - 1'b1;
        end
      end
    end
  end

  assign act_led[0] = (led_cnt[0] != '0);
  assign act_led[1] = (led_cnt[1] != '0);

endmodule

// File: tb/tb_hm2_gpio_infilter.sv
// Directed bench for hm2_gpio_infilter with a short LED stretch so the
// activity indicators can be timed cycle by cycle.
module tb_hm2_gpio_infilter;

  localparam int IOWidth    = 34;
  localparam int FilterBits = 4;
  localparam int LedStretch = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [IOWidth-1:0]    gpio_in;
  logic [IOWidth-1:0]    filter_en;
  logic [FilterBits-1:0] filter_len;
  logic [IOWidth-1:0]    io_filtered;
  logic [IOWidth-1:0]    edge_rise;
  logic [IOWidth-1:0]    edge_fall;
  logic [1:0]            act_led;

  int errors = 0;
  int checks = 0;

  hm2_gpio_infilter #(
    .IOWidth(IOWidth), .FilterBits(FilterBits), .LedStretch(LedStretch)
  ) dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .filter_en(filter_en),
    .filter_len(filter_len), .io_filtered(io_filtered), .edge_rise(edge_rise),
    .edge_fall(edge_fall), .act_led(act_led)
  );

  always #5 clk = ~clk;

  // One tick leaves us just after a rising edge; k ticks after an input change
  // we observe the state right after edge E(k-1).
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; gpio_in = '1; filter_en = '0; filter_len = '0;
    tick(3);
    checks++; if (io_filtered !== '0) begin errors++; $display("[TB] FAIL rst_io: got %h want 0", io_filtered); end
    checks++; if (edge_rise !== '0) begin errors++; $display("[TB] FAIL rst_rise: got %h want 0", edge_rise); end
    checks++; if (edge_fall !== '0) begin errors++; $display("[TB] FAIL rst_fall: got %h want 0", edge_fall); end
    checks++; if (act_led !== 2'b00) begin errors++; $display("[TB] FAIL rst_led: got %b want 00", act_led); end
    reset = 1'b0;
    tick(2);
    checks++; if (io_filtered !== '0) begin errors++; $display("[TB] FAIL rel_e1_io: got %h want 0", io_filtered); end
    tick(1);
    checks++; if (io_filtered !== '1) begin errors++; $display("[TB] FAIL rel_e2_io: got %h want all-ones", io_filtered); end
    checks++; if (edge_rise !== '1) begin errors++; $display("[TB] FAIL rel_e2_rise: got %h want all-ones", edge_rise); end
    checks++; if (edge_fall !== '0) begin errors++; $display("[TB] FAIL rel_e2_fall: got %h want 0", edge_fall); end
    tick(1);
    checks++; if (edge_rise !== '0) begin errors++; $display("[TB] FAIL rel_e3_rise: got %h want 0", edge_rise); end
    checks++; if (act_led !== 2'b11) begin errors++; $display("[TB] FAIL rel_e3_led: got %b want 11", act_led); end
    tick(14);
    checks++; if (act_led !== 2'b11) begin errors++; $display("[TB] FAIL rel_led_last: got %b want 11", act_led); end
    tick(1);
    checks++; if (act_led !== 2'b00) begin errors++; $display("[TB] FAIL rel_led_off: got %b want 00", act_led); end
    gpio_in = '0;
    tick(30);
  endtask

  task automatic test_bypass();
    filter_en = '0; filter_len = '0;
    gpio_in[5] = 1'b1;
    tick(2);
    checks++; if (io_filtered[5] !== 1'b0) begin errors++; $display("[TB] FAIL byp_e1: got %b want 0", io_filtered[5]); end
    tick(1);
    checks++; if (io_filtered !== 34'h20) begin errors++; $display("[TB] FAIL byp_io: got %h want 20", io_filtered); end
    checks++; if (edge_rise !== 34'h20) begin errors++; $display("[TB] FAIL byp_rise: got %h want 20", edge_rise); end
    checks++; if (edge_fall !== '0) begin errors++; $display("[TB] FAIL byp_fall: got %h want 0", edge_fall); end
    tick(1);
    checks++; if (edge_rise !== '0) begin errors++; $display("[TB] FAIL byp_rise_clr: got %h want 0", edge_rise); end
    checks++; if (io_filtered !== 34'h20) begin errors++; $display("[TB] FAIL byp_hold: got %h want 20", io_filtered); end
    gpio_in = '0;
    tick(30);
  endtask

  task automatic test_glitch();
    int bad;
    filter_en = 34'h1; filter_len = 4'd3;
    gpio_in[0] = 1'b1;
    tick(3);
    gpio_in[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (io_filtered[0] !== 1'b0 || edge_rise[0] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL glitch_reject: got %0d bad cycles want 0", bad); end
    gpio_in[0] = 1'b1;
    tick(5);
    checks++; if (io_filtered[0] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_e4: got %b want 0", io_filtered[0]); end
    tick(1);
    checks++; if (io_filtered[0] !== 1'b1) begin errors++; $display("[TB] FAIL glitch_e5_io: got %b want 1", io_filtered[0]); end
    checks++; if (edge_rise !== 34'h1) begin errors++; $display("[TB] FAIL glitch_e5_rise: got %h want 1", edge_rise); end
    gpio_in[0] = 1'b0;
    tick(30);
  endtask

  task automatic test_len_change();
    filter_en = 34'h8; filter_len = 4'd10;
    gpio_in[3] = 1'b1;
    tick(8);
    checks++; if (io_filtered[3] !== 1'b0) begin errors++; $display("[TB] FAIL len_before: got %b want 0", io_filtered[3]); end
    filter_len = 4'd2;
    tick(1);
    checks++; if (io_filtered[3] !== 1'b1) begin errors++; $display("[TB] FAIL len_update: got %b want 1", io_filtered[3]); end
    checks++; if (edge_rise !== 34'h8) begin errors++; $display("[TB] FAIL len_rise: got %h want 8", edge_rise); end
    gpio_in[3] = 1'b0;
    tick(4);
    checks++; if (io_filtered[3] !== 1'b1) begin errors++; $display("[TB] FAIL len_fall_e3: got %b want 1", io_filtered[3]); end
    tick(1);
    checks++; if (io_filtered[3] !== 1'b0) begin errors++; $display("[TB] FAIL len_fall_e4: got %b want 0", io_filtered[3]); end
    checks++; if (edge_fall !== 34'h8) begin errors++; $display("[TB] FAIL len_fall_strobe: got %h want 8", edge_fall); end
    tick(30);
  endtask

  task automatic test_led_stretch();
    int high;
    int bad;
    filter_en = '0; filter_len = '0;
    gpio_in[20] = 1'b1;
    high = 0; bad = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 3 && edge_rise !== (34'h1 << 20)) bad++;
      if (act_led === 2'b10) high++;
      else if (act_led !== 2'b00) bad++;
    end
    checks++; if (high != 15) begin errors++; $display("[TB] FAIL led_single: got %0d cycles want 15", high); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL led_single_bad: got %0d bad want 0", bad); end
    gpio_in[20] = 1'b0;
    high = 0; bad = 0;
    for (int k = 1; k <= 45; k++) begin
      tick(1);
      if (k == 10) gpio_in[20] = 1'b1;
      if (act_led === 2'b10) high++;
      else if (act_led !== 2'b00) bad++;
    end
    checks++; if (high != 25) begin errors++; $display("[TB] FAIL led_reload: got %0d cycles want 25", high); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL led_reload_bad: got %0d bad want 0", bad); end
    gpio_in = '0;
    tick(30);
  endtask

  task automatic test_reset_mid();
    filter_en = 34'h80; filter_len = 4'd5;
    gpio_in[7] = 1'b1;
    tick(6);
    checks++; if (io_filtered[7] !== 1'b0) begin errors++; $display("[TB] FAIL mid_pre: got %b want 0", io_filtered[7]); end
    reset = 1'b1;
    tick(2);
    checks++; if (io_filtered !== '0) begin errors++; $display("[TB] FAIL mid_rst_io: got %h want 0", io_filtered); end
    reset = 1'b0;
    tick(7);
    checks++; if (io_filtered[7] !== 1'b0) begin errors++; $display("[TB] FAIL mid_e6: got %b want 0", io_filtered[7]); end
    tick(1);
    checks++; if (io_filtered[7] !== 1'b1) begin errors++; $display("[TB] FAIL mid_e7_io: got %b want 1", io_filtered[7]); end
    checks++; if (edge_rise !== 34'h80) begin errors++; $display("[TB] FAIL mid_e7_rise: got %h want 80", edge_rise); end
    tick(30);
  endtask

  task automatic test_back_to_back();
    logic [IOWidth-1:0] mask;
    mask = (34'h1 << 1) | (34'h1 << 30);
    filter_en = '0; filter_len = '0;
    gpio_in = gpio_in | mask;
    tick(3);
    checks++; if (edge_rise !== mask) begin errors++; $display("[TB] FAIL b2b_rise: got %h want %h", edge_rise, mask); end
    checks++; if (io_filtered !== (mask | 34'h80)) begin errors++; $display("[TB] FAIL b2b_io: got %h want %h", io_filtered, mask | 34'h80); end
    tick(1);
    checks++; if (act_led !== 2'b11) begin errors++; $display("[TB] FAIL b2b_led: got %b want 11", act_led); end
    gpio_in = gpio_in & ~mask;
    tick(3);
    checks++; if (edge_fall !== mask) begin errors++; $display("[TB] FAIL b2b_fall: got %h want %h", edge_fall, mask); end
    checks++; if (edge_rise !== '0) begin errors++; $display("[TB] FAIL b2b_rise_clr: got %h want 0", edge_rise); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_glitch();
    test_len_change();
    test_led_stretch();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
